// File: rtl/fpu_result_collector.sv
// Result collector for the 6-register FPU datapath: snoops operands at issue, fixes up
// IEEE-754 special values and signs on the way out, and buffers results in a credited FIFO.
module fpu_result_collector #(
    parameter int DataSize     = 32,
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    parameter int PipeLatency  = 6,
    parameter int FifoDepth    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DataSize-1:0] Operand1,
    input  logic [DataSize-1:0] Operand2,
    input  logic [1:0]          Operation,
    input  logic [DataSize-1:0] FpuResult,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DataSize-1:0] out_data,
    output logic [2:0]          out_flags
);

    localparam int MagW = DataSize - 1;
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int InfW = $clog2(PipeLatency + 1);
    localparam int SumW = $clog2(FifoDepth + PipeLatency + 1);

    localparam logic [DataSize-1:0] QNAN =
        {1'b0, {ExponentSize{1'b1}}, 1'b1, {(FractionSize-1){1'b0}}};

    function automatic logic f_is_zero(input logic [DataSize-1:0] v);
        return v[DataSize-2 -: ExponentSize] == '0;
    endfunction

    function automatic logic f_is_inf(input logic [DataSize-1:0] v);
        return (v[DataSize-2 -: ExponentSize] == '1) && (v[FractionSize-1:0] == '0);
    endfunction

    function automatic logic f_is_nan(input logic [DataSize-1:0] v);
        return (v[DataSize-2 -: ExponentSize] == '1) && (v[FractionSize-1:0] != '0);
    endfunction

    function automatic logic [DataSize-1:0] f_inf(input logic s);
        return {s, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
    endfunction

    function automatic logic [DataSize-1:0] f_zero(input logic s);
        return {s, {MagW{1'b0}}};
    endfunction

    // Issue-time operand classification
    logic w_issue;
    logic w_s1, w_s2, w_s2e;
    logic w_z1, w_i1, w_n1, w_z2, w_i2, w_n2;
    logic w_is_muldiv, w_is_mul, w_is_div;
    logic [MagW-1:0] w_mag1, w_mag2;

    assign w_issue     = in_valid & in_ready;
    assign w_s1        = Operand1[DataSize-1];
    assign w_s2        = Operand2[DataSize-1];
    assign w_s2e       = w_s2 ^ (Operation == 2'b01);
    assign w_mag1      = Operand1[MagW-1:0];
    assign w_mag2      = Operand2[MagW-1:0];
    assign w_z1        = f_is_zero(Operand1);
    assign w_i1        = f_is_inf(Operand1);
    assign w_n1        = f_is_nan(Operand1);
    assign w_z2        = f_is_zero(Operand2);
    assign w_i2        = f_is_inf(Operand2);
    assign w_n2        = f_is_nan(Operand2);
    assign w_is_muldiv = Operation[1];
    assign w_is_mul    = (Operation == 2'b10);
    assign w_is_div    = (Operation == 2'b11);

    logic                w_sign;
    logic                w_invalid;
    logic                w_use_fpu;
    logic [DataSize-1:0] w_ovr_word;
    logic [2:0]          w_flags;

    always_comb begin
        w_sign     = 1'b0;
        w_invalid  = 1'b0;
        w_use_fpu  = 1'b0;
        w_ovr_word = '0;
        w_flags    = 3'b000;

        if (w_is_muldiv)
            w_sign = w_s1 ^ w_s2;
        else if (w_mag1 > w_mag2)
            w_sign = w_s1;
        else if (w_mag1 < w_mag2)
            w_sign = w_s2e;
        else
            w_sign = (w_s1 == w_s2e) ? w_s1 : 1'b0;

        w_invalid = w_n1 | w_n2
                  | (!w_is_muldiv & w_i1 & w_i2 & (w_s1 ^ w_s2e))
                  | (w_is_mul & ((w_z1 & w_i2) | (w_i1 & w_z2)))
                  | (w_is_div & ((w_z1 & w_z2) | (w_i1 & w_i2)));

        // Special-value overrides, highest priority first
        if (w_invalid) begin
            w_ovr_word = QNAN;
            w_flags    = 3'b101;
        end else if (w_is_div && w_z2 && !w_z1 && !w_i1) begin
            w_ovr_word = f_inf(w_sign);
            w_flags    = 3'b011;
        end else if (w_i1 || w_i2) begin
            w_flags = 3'b001;
            if (!w_is_muldiv)
                w_ovr_word = f_inf(w_i1 ? w_s1 : w_s2e);
            else if (w_is_div && w_i2)
                w_ovr_word = f_zero(w_sign);
            else
                w_ovr_word = f_inf(w_sign);
        end else if (w_z1 || w_z2) begin
            w_flags = 3'b001;
            if (w_is_muldiv)
                w_ovr_word = f_zero(w_sign);
            else if (w_z1)
                w_ovr_word = {w_s2e, w_mag2};
            else
                w_ovr_word = Operand1;
        end else begin
            w_use_fpu = 1'b1;
        end
    end

    // Delay line matching the FPU latency; only the valid bits carry reset
    logic [PipeLatency-1:0] r_vld_p;
    logic [DataSize-1:0]    r_word_p  [PipeLatency];
    logic [2:0]             r_flags_p [PipeLatency];
    logic                   r_sign_p  [PipeLatency];
    logic                   r_fpu_p   [PipeLatency];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_issue;
            for (int k = 1; k < PipeLatency; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        r_word_p[0]  <= w_ovr_word;
        r_flags_p[0] <= w_flags;
        r_sign_p[0]  <= w_sign;
        r_fpu_p[0]   <= w_use_fpu;
        for (int k = 1; k < PipeLatency; k++) begin
            r_word_p[k]  <= r_word_p[k-1];
            r_flags_p[k] <= r_flags_p[k-1];
            r_sign_p[k]  <= r_sign_p[k-1];
            r_fpu_p[k]   <= r_fpu_p[k-1];
        end
    end

    // Tail of the delay line lines up with FpuResult; the datapath's sign bit is replaced
    logic                w_push;
    logic [DataSize-1:0] w_push_data;
    logic [2:0]          w_push_flags;
    logic                w_unused_fpu_sign;

    assign w_unused_fpu_sign = FpuResult[DataSize-1];
    assign w_push            = r_vld_p[PipeLatency-1];
    assign w_push_flags      = r_flags_p[PipeLatency-1];
    assign w_push_data       = r_fpu_p[PipeLatency-1]
                             ? {r_sign_p[PipeLatency-1], FpuResult[MagW-1:0]}
                             : r_word_p[PipeLatency-1];

    // Output FIFO with a registered head
    logic [DataSize-1:0] r_mem_data  [FifoDepth];
    logic [2:0]          r_mem_flags [FifoDepth];
    logic [PtrW-1:0]     r_wr, r_rd;
    logic [CntW-1:0]     r_count;
    logic [InfW-1:0]     r_inflight;
    logic                r_out_valid;
    logic [DataSize-1:0] r_out_data;
    logic [2:0]          r_out_flags;

    logic                w_pop;
    logic [CntW-1:0]     w_count_nxt;
    logic [CntW-1:0]     w_count_left;
    logic [PtrW-1:0]     w_rd_nxt;
    logic                w_fwd;
    logic [SumW-1:0]     w_credit_sum;

    assign w_pop        = r_out_valid & out_ready;
    assign w_count_left = r_count - CntW'(w_pop);
    assign w_count_nxt  = w_count_left + CntW'(w_push);
    assign w_rd_nxt     = r_rd + PtrW'(w_pop);
    // Entry arriving into an otherwise empty FIFO goes straight to the head register
    assign w_fwd        = w_push && (w_count_left == '0);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr]  <= w_push_data;
            r_mem_flags[r_wr] <= w_push_flags;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_inflight  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flags <= 3'b000;
        end else begin
            r_wr        <= r_wr + PtrW'(w_push);
            r_rd        <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_inflight  <= r_inflight + InfW'(w_issue) - InfW'(w_push);
            r_out_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_out_data  <= w_fwd ? w_push_data  : r_mem_data[w_rd_nxt];
                r_out_flags <= w_fwd ? w_push_flags : r_mem_flags[w_rd_nxt];
            end
        end
    end

    // Credits come from registered state only, so a same-cycle pop never frees a slot early
    assign w_credit_sum = SumW'(r_count) + SumW'(r_inflight);
    assign in_ready     = (w_credit_sum < SumW'(FifoDepth));

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector: models the FPU as a plain delay of a
// per-vector result word and checks outputs against hand-computed expectations.
module tb_fpu_result_collector;

    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int NV    = 18;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Operand1 = '0;
    logic [31:0] Operand2 = '0;
    logic [1:0]  Operation = '0;
    logic [31:0] FpuResult;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    fpu_result_collector #(
        .DataSize(32), .ExponentSize(8), .FractionSize(23),
        .PipeLatency(LAT), .FifoDepth(DEPTH)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .Operand1(Operand1), .Operand2(Operand2), .Operation(Operation),
        .FpuResult(FpuResult),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] fpu;
        logic [31:0] exp_d;
        logic [2:0]  exp_f;
    } vec_t;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    vec_t        vecs [NV];
    logic [31:0] cur_fpu = '0;
    logic [31:0] cur_exp = '0;
    logic [2:0]  cur_flg = '0;
    logic [31:0] fpu_pipe [LAT];
    logic [34:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_issued = 0;

    assign FpuResult = fpu_pipe[LAT-1];

    // Behavioural stand-in for the FPU datapath plus issue bookkeeping
    always @(posedge CLK) begin
        if (RST_N && in_valid && in_ready) begin
            exp_q.push_back({cur_exp, cur_flg});
            n_issued++;
        end
        fpu_pipe[0] <= (in_valid && in_ready) ? cur_fpu : 32'hDEADBEEF;
        for (int k = 1; k < LAT; k++)
            fpu_pipe[k] <= fpu_pipe[k-1];
    end

    always @(negedge CLK) begin
        logic [34:0] e;
        if (RST_N && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got data=%h flags=%b, required no output",
                         out_data, out_flags);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_flags} !== e) begin
                    n_bad++;
                    $display("FAIL result got data=%h flags=%b, required data=%h flags=%b",
                             out_data, out_flags, e[34:3], e[2:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic drive(input int i);
        Operation = vecs[i].op;
        Operand1  = vecs[i].a;
        Operand2  = vecs[i].b;
        cur_fpu   = vecs[i].fpu;
        cur_exp   = vecs[i].exp_d;
        cur_flg   = vecs[i].exp_f;
    endtask

    // Issues cnt operations from the table; called just after a rising edge
    task automatic stream(input int cnt, input bit rnd);
        int target;
        int c;
        target = n_issued + cnt;
        for (c = 0; c < 2000 && n_issued < target; c++) begin
            drive(n_issued % NV);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (n_issued < target)
            chk("stream_timeout", 64'(n_issued), 64'(target));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++)
            @(posedge CLK);
        #1;
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        vecs[0]  = '{ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 32'h40700000, 3'b000};
        vecs[1]  = '{MUL, 32'hBFC00000, 32'h40000000, 32'h40400000, 32'hC0400000, 3'b000};
        vecs[2]  = '{SUB, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'hBF800000, 3'b000};
        vecs[3]  = '{SUB, 32'h7F800000, 32'h7F800000, 32'h12345678, 32'h7FC00000, 3'b101};
        vecs[4]  = '{DIV, 32'h3F800000, 32'h00000000, 32'h12345678, 32'h7F800000, 3'b011};
        vecs[5]  = '{ADD, 32'h00000000, 32'hC0A00000, 32'h12345678, 32'hC0A00000, 3'b001};
        vecs[6]  = '{MUL, 32'h00000000, 32'h7F800000, 32'h12345678, 32'h7FC00000, 3'b101};
        vecs[7]  = '{ADD, 32'h7FC00001, 32'h3F800000, 32'h12345678, 32'h7FC00000, 3'b101};
        vecs[8]  = '{DIV, 32'h40000000, 32'h7F800000, 32'h12345678, 32'h00000000, 3'b001};
        vecs[9]  = '{DIV, 32'hC0000000, 32'h00000000, 32'h12345678, 32'hFF800000, 3'b011};
        vecs[10] = '{SUB, 32'h40400000, 32'hC0400000, 32'h40C00000, 32'h40C00000, 3'b000};
        vecs[11] = '{ADD, 32'h40400000, 32'hC0400000, 32'h80000000, 32'h00000000, 3'b000};
        vecs[12] = '{SUB, 32'h40000000, 32'h00000000, 32'h12345678, 32'h40000000, 3'b001};
        vecs[13] = '{ADD, 32'hFF800000, 32'h3F800000, 32'h12345678, 32'hFF800000, 3'b001};
        vecs[14] = '{DIV, 32'h00000000, 32'h40000000, 32'h12345678, 32'h00000000, 3'b001};
        vecs[15] = '{MUL, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'hC0000000, 3'b000};
        vecs[16] = '{DIV, 32'h7F800000, 32'h7F800000, 32'h12345678, 32'h7FC00000, 3'b101};
        vecs[17] = '{MUL, 32'h7F800000, 32'hC0000000, 32'h12345678, 32'hFF800000, 3'b001};

        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);

        // Single issue: out_valid rises on the 7th edge counting the issue edge
        out_ready = 1'b1;
        drive(0);
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        chk("lat_issued", 64'(n_issued), 64'd1);
        repeat (5) @(posedge CLK);
        #1;
        chk("lat_edge6_valid", 64'(out_valid), 64'd0);
        @(posedge CLK);
        #1;
        chk("lat_edge7_valid", 64'(out_valid), 64'd1);
        wait_drain();

        // Whole table back-to-back
        stream(NV, 1'b0);
        wait_drain();

        // Random in_valid gaps
        stream(2 * NV, 1'b1);
        wait_drain();

        // Fill: credits stop issue at exactly FifoDepth
        out_ready = 1'b0;
        base = n_issued;
        for (int c = 0; c < 12; c++) begin
            drive(n_issued % NV);
            in_valid = 1'b1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        chk("full_issue_count", 64'(n_issued - base), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        repeat (10) @(posedge CLK);
        #1;
        chk("full_in_ready_late", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("ready_after_pop", 64'(in_ready), 64'd1);
        wait_drain();

        // Asynchronous reset with results queued and operations in flight
        out_ready = 1'b0;
        stream(3, 1'b0);
        repeat (8) @(posedge CLK);
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        stream(4, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_data", 64'(out_data), 64'd0);
        chk("async_out_flags", 64'(out_flags), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        stream(3, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "timeout");
    end

endmodule
